// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data RAM responder: FSM states, counter width,
// big-endian lane-select codes and the alignment legality rule.
package data_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int CNT_W = 3;

  // Byte offset 00 lives in sel[3] / bits 31:24.
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  function automatic logic sel_legal(input logic [1:0] off, input logic [3:0] sel);
    logic ok;
    case (off)
      2'b00:   ok = (sel != 4'b0000);
      2'b01:   ok = (sel == SEL_B1);
      2'b10:   ok = (sel == SEL_B2) || (sel == SEL_H1);
      default: ok = (sel == SEL_B3);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// Four byte-wide lanes of 2^ADDR_WIDTH words: synchronous per-lane write and a
// registered whole-word read, both qualified by a single access strobe.
module data_ram_bank
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // NOTE: the array and its read register have no reset; contents must survive a reset and RAM macros cannot be cleared in one cycle.
    always_ff @(posedge clk) begin
      if (en && we && be[l]) mem[addr] <= wdata[8*l +: 8];
      if (en && !we)         rd_q      <= mem[addr];
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// MEM-stage data memory responder: latches one request, waits WAIT_STATES cycles,
// commits on entry to RESP and acknowledges for one cycle. Optional alignment
// check enabled by defining DATA_RAM_ALIGN_CHECK_EN (adds addr_err_o).
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stallreq_o
`ifdef DATA_RAM_ALIGN_CHECK_EN
  ,
  output logic        addr_err_o
`endif
);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic                   we_q;
  logic [3:0]             sel_q;
  logic [31:0]            wdata_q;
  logic                   ack_q;
  logic                   rd_resp_q;

  logic                   accept;
  logic                   enter_resp;
  logic                   req_we;
  logic                   req_bad;
  logic [ADDR_WIDTH-1:0]  req_idx;
  logic [3:0]             req_sel;
  logic [31:0]            req_wdata;
  logic [31:0]            bank_rdata;
  logic                   unused_addr;

  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  assign accept     = (state == ST_IDLE) && ce_i;
  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (cnt == CNT_W'(1)));

  // With zero wait states the commit edge is also the latch edge, so use the live inputs.
  assign req_idx   = accept ? addr_i[ADDR_WIDTH+1:2] : idx_q;
  assign req_we    = accept ? we_i   : we_q;
  assign req_sel   = accept ? sel_i  : sel_q;
  assign req_wdata = accept ? data_i : wdata_q;

`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic in_bad;
  logic bad_q;
  logic err_q;

  assign in_bad  = !sel_legal(addr_i[1:0], sel_i);
  assign req_bad = accept ? in_bad : bad_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) bad_q <= in_bad;
      err_q <= enter_resp && req_bad;
    end
  end

  assign addr_err_o = err_q;
`else
  assign req_bad = 1'b0;
`endif

  data_ram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clk   (clk),
    .en    (enter_resp && !req_bad),
    .we    (req_we),
    .be    (req_sel),
    .addr  (req_idx),
    .wdata (req_wdata),
    .rdata (bank_rdata)
  );

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      rd_resp_q <= 1'b0;
    end else begin
      ack_q     <= enter_resp;
      rd_resp_q <= enter_resp && !req_we && !req_bad;
      case (state)
        ST_IDLE: begin
          if (ce_i) begin
            idx_q   <= addr_i[ADDR_WIDTH+1:2];
            we_q    <= we_i;
            sel_q   <= sel_i;
            wdata_q <= data_i;
            cnt     <= CNT_W'(WAIT_STATES);
            state   <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign data_o = rd_resp_q ? bank_rdata : 32'h0;

  // Gated by rst so a request held during reset does not stall the pipeline.
  assign stallreq_o = rst && (accept || (state == ST_WAIT));

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: directed scenarios plus randomized
// accesses compared against a word-array reference model.
module tb_data_ram_ctrl;

  localparam int AW = 12;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        ack_o;
  logic        stallreq_o;
  logic        err_sig;

`ifdef DATA_RAM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
  assign err_sig = 1'b0;
`endif

  data_ram_ctrl #(
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .sel_i      (sel_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .stallreq_o (stallreq_o)
`ifdef DATA_RAM_ALIGN_CHECK_EN
    ,
    .addr_err_o (err_sig)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit side_bad = 1'b0;

  logic [31:0] model [int];

  function automatic bit legal(input logic [1:0] off, input logic [3:0] sel);
    if (off == 2'd0) return sel != 4'h0;
    if (off == 2'd1) return sel == 4'b0100;
    if (off == 2'd2) return (sel == 4'b0010) || (sel == 4'b0011);
    return sel == 4'b0001;
  endfunction

  function automatic int word_idx(input logic [31:0] addr);
    return int'((addr >> 2) % (32'd1 << AW));
  endfunction

  function automatic bit exp_err(input logic [31:0] addr, input logic [3:0] sel);
    return ALIGN_EN && !legal(addr[1:0], sel);
  endfunction

  function automatic logic [31:0] exp_rd(input bit we, input logic [31:0] addr, input logic [3:0] sel);
    if (we || exp_err(addr, sel)) return 32'h0;
    if (!model.exists(word_idx(addr))) return 32'hxxxx_xxxx;
    return model[word_idx(addr)];
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [3:0] sel,
                                      input logic [31:0] data);
    logic [31:0] w;
    if (exp_err(addr, sel)) return;
    w = model.exists(word_idx(addr)) ? model[word_idx(addr)] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (sel[b]) w[8*b +: 8] = data[8*b +: 8];
    model[word_idx(addr)] = w;
  endfunction

  // Issues one access starting in an IDLE cycle; returns ack latency (-1 on timeout),
  // number of cycles with stallreq_o high, and the data/error seen with ack_o.
  task automatic xfer(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] data, output int lat, output int stalls,
                      output logic [31:0] rd, output logic err);
    ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
    lat = -1; stalls = 0; rd = '0; err = 1'b0;
    #1;
    if (stallreq_o) stalls++;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        lat = k; rd = data_o; err = err_sig; ce_i = 1'b0;
      end else begin
        if (stallreq_o) stalls++;
        if (data_o !== 32'h0 || err_sig !== 1'b0) side_bad = 1'b1;
      end
    end
    ce_i = 1'b0;
    @(posedge clk); #1;
    if (ack_o !== 1'b0 || data_o !== 32'h0 || err_sig !== 1'b0) side_bad = 1'b1;
    if (we && lat > 0) model_write(addr, sel, data);
  endtask

  task automatic test_reset();
    ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; sel_i = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (ack_o !== 1'b0 || stallreq_o !== 1'b0 || data_o !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs: ack=%b stall=%b data=%h expected 0 0 00000000",
                 ack_o, stallreq_o, data_o);
      end
    end
    ce_i = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_round_trip();
    int lat, stalls; logic [31:0] rd; logic err;
    xfer(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, lat, stalls, rd, err);
    checks++;
    if (lat !== WS + 1 || stalls !== WS + 1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL word_write: lat=%0d stalls=%0d data=%h expected %0d %0d 00000000",
               lat, stalls, rd, WS + 1, WS + 1);
    end
    xfer(1'b0, 32'h100, 4'hF, 32'h0, lat, stalls, rd, err);
    checks++;
    if (lat !== WS + 1 || stalls !== WS + 1 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_read: lat=%0d stalls=%0d data=%h expected %0d %0d deadbeef",
               lat, stalls, rd, WS + 1, WS + 1);
    end
  endtask

  task automatic test_byte_write();
    int lat, stalls; logic [31:0] rd; logic err;
    xfer(1'b1, 32'h101, 4'b0100, 32'hAAAAAAAA, lat, stalls, rd, err);
    xfer(1'b0, 32'h100, 4'hF, 32'h0, lat, stalls, rd, err);
    checks++;
    if (rd !== 32'hDEAABEEF) begin
      failures++;
      $display("FAIL byte_write: got %h expected deaabeef", rd);
    end
  endtask

  task automatic test_zero_sel();
    int lat, stalls; logic [31:0] rd; logic err; logic [31:0] exp;
    xfer(1'b1, 32'h100, 4'h0, $urandom, lat, stalls, rd, err);
    checks++;
    if (lat !== WS + 1 || err !== exp_err(32'h100, 4'h0)) begin
      failures++;
      $display("FAIL zero_sel_ack: lat=%0d err=%b expected %0d %b",
               lat, err, WS + 1, exp_err(32'h100, 4'h0));
    end
    exp = exp_rd(1'b0, 32'h100, 4'hF);
    xfer(1'b0, 32'h100, 4'hF, 32'h0, lat, stalls, rd, err);
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL zero_sel_data: got %h expected %h", rd, exp);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, stalls; logic [31:0] rd; logic err; bit saw_ack;
    xfer(1'b1, 32'h200, 4'hF, 32'h0, lat, stalls, rd, err);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h200; sel_i = 4'hF; data_i = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b0; ce_i = 1'b0;
    saw_ack = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_o !== 1'b0 || stallreq_o !== 1'b0) saw_ack = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (ack_o !== 1'b0) saw_ack = 1'b1;
    checks++;
    if (saw_ack) begin
      failures++;
      $display("FAIL reset_mid_no_ack: ack/stall seen during or after reset, expected none");
    end
    xfer(1'b0, 32'h200, 4'hF, 32'h0, lat, stalls, rd, err);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_data: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_wrap();
    int lat, stalls; logic [31:0] rd; logic err;
    xfer(1'b1, 32'h4100, 4'hF, 32'hCAFEF00D, lat, stalls, rd, err);
    xfer(1'b0, 32'h100, 4'hF, 32'h0, lat, stalls, rd, err);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL wrap: got %h expected cafef00d", rd);
    end
  endtask

`ifdef DATA_RAM_ALIGN_CHECK_EN
  task automatic test_align();
    int lat, stalls; logic [31:0] rd; logic err; logic [31:0] exp;
    exp = exp_rd(1'b0, 32'h100, 4'hF);
    xfer(1'b1, 32'h102, 4'hF, 32'h11111111, lat, stalls, rd, err);
    checks++;
    if (lat !== WS + 1 || err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL align_err: lat=%0d err=%b data=%h expected %0d 1 00000000",
               lat, err, rd, WS + 1);
    end
    xfer(1'b0, 32'h100, 4'hF, 32'h0, lat, stalls, rd, err);
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL align_suppress: got %h expected %h", rd, exp);
    end
  endtask
`endif

  task automatic test_random();
    int idxs [8] = '{0, 1, 2, 'h40, 'h80, 'hFFF, 'h123, 'h7FE};
    int lat, stalls; logic [31:0] rd; logic err;
    logic [31:0] addr, data, exp_d; logic [3:0] sel; bit we, exp_e;
    foreach (idxs[i]) begin
      xfer(1'b1, idxs[i] << 2, 4'hF, $urandom, lat, stalls, rd, err);
      checks++;
      if (lat !== WS + 1) begin
        failures++;
        $display("FAIL rand_init_lat: got %0d expected %0d", lat, WS + 1);
      end
    end
    for (int n = 0; n < 60; n++) begin
      addr  = ($urandom << (AW + 2)) | (idxs[$urandom_range(0, 7)] << 2) | $urandom_range(0, 3);
      sel   = 4'($urandom_range(0, 15));
      we    = 1'($urandom_range(0, 1));
      data  = $urandom;
      exp_d = exp_rd(we, addr, sel);
      exp_e = exp_err(addr, sel);
      xfer(we, addr, sel, data, lat, stalls, rd, err);
      checks++;
      if (lat !== WS + 1 || stalls !== WS + 1) begin
        failures++;
        $display("FAIL rand_timing: addr=%h lat=%0d stalls=%0d expected %0d %0d",
                 addr, lat, stalls, WS + 1, WS + 1);
      end
      checks++;
      if (rd !== exp_d || err !== exp_e) begin
        failures++;
        $display("FAIL rand_data: addr=%h we=%b sel=%b got %h/%b expected %h/%b",
                 addr, we, sel, rd, err, exp_d, exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_round_trip();
    test_byte_write();
    test_zero_sel();
    test_reset_mid_access();
    test_wrap();
`ifdef DATA_RAM_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    checks++;
    if (side_bad) begin
      failures++;
      $display("FAIL idle_outputs: data_o/ack_o/addr_err nonzero outside the response cycle");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
